fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 16-bit single-issue core. Owns the program counter, drives the 8-bit address into the combinational instruction memory, and registers the returned 16-bit word into a fetch/decode pipeline register with a valid/ready handshake. Accepts branch redirects from execute and stops fetching after a halt instruction.

## Interface
- ADDR_W, 8, PC and instruction-memory address width
- INST_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- HALT_OP, 4'b1100, opcode field (inst[15:12]) of halt

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_addr  out  ADDR_W  address to instruction memory; equals internal PC
- imem_inst  in  INST_W  instruction memory read data, combinational from imem_addr
- if_valid  out  1  fetch/decode register holds a live instruction
- if_ready  in  1  decode accepts the instruction this cycle
- if_inst  out  INST_W  registered instruction
- if_pc  out  ADDR_W  address the registered instruction was fetched from
- redir_valid  in  1  execute resolved a taken branch; squash and refetch
- redir_pc  in  ADDR_W  redirect target (execute computes PC + sext(imm4))
- halt_commit  in  1  execute retired the halt instruction
- halted  out  1  core stopped; terminal until reset

## Operation
- States: FETCH, HALT_WAIT, HALTED.
- Fetch-accept: in FETCH, register load occurs when !redir_valid && (!if_valid || if_ready). On load: if_inst <= imem_inst, if_pc <= pc, if_valid <= 1, pc <= pc + 1 (mod 2^ADDR_W; 8'hFF wraps to 8'h00).
- Stall: if_valid && !if_ready && !redir_valid: pc, if_inst, if_pc, if_valid all hold.
- Drain: if_ready && no load (HALT_WAIT/HALTED): if_valid <= 0.
- Halt fetch: on load with imem_inst[15:12] == HALT_OP: FETCH -> HALT_WAIT; pc still increments; no further loads.
- Redirect (any state but HALTED): pc <= redir_pc, if_valid <= 0 (in-flight instruction squashed regardless of if_ready), state -> FETCH (cancels a speculative halt). if_inst/if_pc hold.
- halt_commit (any state): state -> HALTED, if_valid <= 0, halted <= 1. Priority over redir_valid in the same cycle.
- HALTED: redir_valid ignored, no loads, pc holds; exit only via rst_n.
- Priority per cycle: halt_commit > redir_valid > stall > load.

## Timing
- Reset (async assert, sync to clk on deassert by upstream): pc = RESET_PC, if_valid = 0, if_inst = 0, if_pc = 0, halted = 0, state = FETCH.
- First load on first rising edge after rst_n deasserts: if_valid = 1, if_pc = RESET_PC at that edge.
- Fetch latency 1 cycle: word at pc appears on if_inst the edge after pc is presented.
- Throughput 1 instruction/cycle with if_ready held high.
- Redirect penalty: redir_valid at edge N -> if_valid = 0 after N, if_pc = redir_pc after N+1.
- halted rises the edge halt_commit is sampled; stays 1.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous), no pending redirect or halt survives.
- imem_addr combinational from pc register only; no input-to-output combinational paths.

## Structure
- Shared package core_pkg: ADDR_W/INST_W constants, opcode constants (OP_ADD 4'b0000, OP_ADDI 4'b0100, OP_SUBI 4'b0101, OP_BEQZ 4'b1001, OP_HALT 4'b1100), fetch state enum.
- Single module; no sub-module needed. PC register and pipeline register live in one always block with async reset; next-state logic in a combinational block.

## Test plan
- Reset then if_ready=1, memory holding the Fib(3) program: if_pc sequence 0,1,2,3,... one per cycle, if_inst[0] = 16'h4103.
- if_ready=0 for 3 cycles while if_valid=1, if_pc=2: if_pc/if_inst hold at 2/16'h4401, imem_addr holds at 3; resume yields if_pc=3 next.
- redir_valid with redir_pc=8'h03 while if_pc=8: next cycle if_valid=0, following cycle if_pc=3 if_inst=16'h9016; same with if_ready=0 gives identical result.
- Halt at address 9 fetched: state HALT_WAIT, no load of address 10; halt_commit -> halted=1, if_valid=0; later redir_valid ignored.
- Halt fetched then redir_valid (pc 8'h03) before halt_commit: fetching resumes at 3, halted stays 0; halt_commit and redir_valid same cycle -> halted=1.
- RESET_PC=8'hFE: if_pc 8'hFE, 8'hFF, 8'h00; rst_n asserted mid-stream clears if_valid and pc immediately without clock.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit single-issue core: widths, opcodes and
// the fetch-stage state encoding.
package core_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_BEQZ = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1100;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

  // Opcode lives in the top nibble of every instruction word.
  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and holds the fetched word in the fetch/decode register.
module fetch_unit #(
  parameter int               ADDR_W   = core_pkg::ADDR_W,
  parameter int               INST_W   = core_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = core_pkg::OP_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              halt_commit,
  output logic              halted
);

  import core_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              halted_q, halted_d;

  logic [3:0]        fetched_op;
  logic              stall;

  assign fetched_op = imem_inst[INST_W-1 -: 4];
  assign stall      = if_valid_q && !if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      halted_q   <= halted_d;
    end
  end

  // Priority: halt_commit > redirect > stall > load (or drain once halting).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    halted_d   = halted_q;

    if (halt_commit) begin
      state_d    = HALTED;
      if_valid_d = 1'b0;
      halted_d   = 1'b1;
    end else if (state_q == HALTED) begin
      if_valid_d = 1'b0;
    end else if (redir_valid) begin
      // The squashed word keeps its if_inst/if_pc; only valid drops.
      state_d    = FETCH;
      pc_d       = redir_pc;
      if_valid_d = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == FETCH) begin
      if_inst_d  = imem_inst;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 1'b1;
      if (fetched_op == HALT_OP) begin
        state_d = HALT_WAIT;
      end
    end else if (if_ready) begin
      if_valid_d = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors against a
// small program, plus hand sequences for PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_inst;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_inst;
  logic [7:0]  if_pc;
  logic        redir_valid;
  logic [7:0]  redir_pc;
  logic        halt_commit;
  logic        halted;

  logic        w_rst_n;
  logic [7:0]  w_addr;
  logic [15:0] w_inst;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_if_inst;
  logic [7:0]  w_if_pc;
  logic        w_redir;
  logic [7:0]  w_redir_pc;
  logic        w_halt_c;
  logic        w_halted;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] imem(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h4103;
      8'd1:    return 16'h4201;
      8'd2:    return 16'h4401;
      8'd3:    return 16'h9016;
      8'd4:    return 16'h0312;
      8'd5:    return 16'h5101;
      8'd6:    return 16'h4301;
      8'd7:    return 16'h0120;
      8'd8:    return 16'h9F16;
      8'd9:    return 16'hC000;
      8'd10:   return 16'h4500;
      default: return {8'h01, a};
    endcase
  endfunction

  assign imem_inst = imem(imem_addr);
  assign w_inst    = imem(w_addr);

  fetch_unit u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .halt_commit(halt_commit),
    .halted     (halted)
  );

  fetch_unit #(.RESET_PC(8'hFE)) u_wrap (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .imem_addr  (w_addr),
    .imem_inst  (w_inst),
    .if_valid   (w_valid),
    .if_ready   (w_ready),
    .if_inst    (w_if_inst),
    .if_pc      (w_if_pc),
    .redir_valid(w_redir),
    .redir_pc   (w_redir_pc),
    .halt_commit(w_halt_c),
    .halted     (w_halted)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic        hc;
    logic        ev;
    logic [7:0]  epc;
    logic [15:0] einst;
    logic [7:0]  eaddr;
    logic        eh;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic rv, input logic [7:0] rpc,
                     input logic hc, input logic ev, input logic [7:0] epc,
                     input logic [15:0] einst, input logic [7:0] eaddr,
                     input logic eh);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hc = hc;
    v.ev = ev; v.epc = epc; v.einst = einst; v.eaddr = eaddr; v.eh = eh;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic ev, input logic [7:0] epc,
                          input logic [15:0] einst, input logic [7:0] eaddr,
                          input logic eh);
    chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, ev});
    chk({tag, ".if_pc"},     {24'd0, if_pc},    {24'd0, epc});
    chk({tag, ".if_inst"},   {16'd0, if_inst},  {16'd0, einst});
    chk({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, eaddr});
    chk({tag, ".halted"},    {31'd0, halted},   {31'd0, eh});
  endtask

  initial begin
    rst_n = 1'b0; if_ready = 1'b1; redir_valid = 1'b0; redir_pc = 8'h00;
    halt_commit = 1'b0;
    w_rst_n = 1'b0; w_ready = 1'b1; w_redir = 1'b0; w_redir_pc = 8'h00;
    w_halt_c = 1'b0;

    // rdy rv rpc hc | valid pc inst addr halted
    add(1,0,8'h00,0, 1,8'd0,16'h4103,8'd1, 0);
    add(1,0,8'h00,0, 1,8'd1,16'h4201,8'd2, 0);
    add(1,0,8'h00,0, 1,8'd2,16'h4401,8'd3, 0);
    add(0,0,8'h00,0, 1,8'd2,16'h4401,8'd3, 0);
    add(0,0,8'h00,0, 1,8'd2,16'h4401,8'd3, 0);
    add(0,0,8'h00,0, 1,8'd2,16'h4401,8'd3, 0);
    add(1,0,8'h00,0, 1,8'd3,16'h9016,8'd4, 0);
    add(1,0,8'h00,0, 1,8'd4,16'h0312,8'd5, 0);
    add(1,0,8'h00,0, 1,8'd5,16'h5101,8'd6, 0);
    add(1,0,8'h00,0, 1,8'd6,16'h4301,8'd7, 0);
    add(1,0,8'h00,0, 1,8'd7,16'h0120,8'd8, 0);
    add(1,0,8'h00,0, 1,8'd8,16'h9F16,8'd9, 0);
    add(1,1,8'h03,0, 0,8'd8,16'h9F16,8'd3, 0);
    add(1,0,8'h00,0, 1,8'd3,16'h9016,8'd4, 0);
    add(1,0,8'h00,0, 1,8'd4,16'h0312,8'd5, 0);
    add(1,0,8'h00,0, 1,8'd5,16'h5101,8'd6, 0);
    add(1,0,8'h00,0, 1,8'd6,16'h4301,8'd7, 0);
    add(1,0,8'h00,0, 1,8'd7,16'h0120,8'd8, 0);
    add(1,0,8'h00,0, 1,8'd8,16'h9F16,8'd9, 0);
    add(0,1,8'h03,0, 0,8'd8,16'h9F16,8'd3, 0);
    add(0,0,8'h00,0, 1,8'd3,16'h9016,8'd4, 0);
    add(1,0,8'h00,0, 1,8'd4,16'h0312,8'd5, 0);
    add(1,0,8'h00,0, 1,8'd5,16'h5101,8'd6, 0);
    add(1,0,8'h00,0, 1,8'd6,16'h4301,8'd7, 0);
    add(1,0,8'h00,0, 1,8'd7,16'h0120,8'd8, 0);
    add(1,0,8'h00,0, 1,8'd8,16'h9F16,8'd9, 0);
    add(1,0,8'h00,0, 1,8'd9,16'hC000,8'd10,0);
    add(0,0,8'h00,0, 1,8'd9,16'hC000,8'd10,0);
    add(1,0,8'h00,0, 0,8'd9,16'hC000,8'd10,0);
    add(1,0,8'h00,0, 0,8'd9,16'hC000,8'd10,0);
    add(1,1,8'h03,0, 0,8'd9,16'hC000,8'd3, 0);
    add(1,0,8'h00,0, 1,8'd3,16'h9016,8'd4, 0);
    add(1,0,8'h00,0, 1,8'd4,16'h0312,8'd5, 0);
    add(1,0,8'h00,0, 1,8'd5,16'h5101,8'd6, 0);
    add(1,0,8'h00,0, 1,8'd6,16'h4301,8'd7, 0);
    add(1,0,8'h00,0, 1,8'd7,16'h0120,8'd8, 0);
    add(1,0,8'h00,0, 1,8'd8,16'h9F16,8'd9, 0);
    add(1,0,8'h00,0, 1,8'd9,16'hC000,8'd10,0);
    add(1,1,8'h03,1, 0,8'd9,16'hC000,8'd10,1);
    add(1,1,8'h03,0, 0,8'd9,16'hC000,8'd10,1);
    add(1,0,8'h00,0, 0,8'd9,16'hC000,8'd10,1);

    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if_ready    = tbl[i].rdy;
      redir_valid = tbl[i].rv;
      redir_pc    = tbl[i].rpc;
      halt_commit = tbl[i].hc;
      @(posedge clk);
      #1;
      chk_main($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einst,
               tbl[i].eaddr, tbl[i].eh);
    end
    if_ready = 1'b1; redir_valid = 1'b0; halt_commit = 1'b0;

    // Asynchronous reset out of HALTED, then again mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk_main("arst_halted", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_main("rerun0", 1'b1, 8'd0, 16'h4103, 8'd1, 1'b0);
    @(posedge clk);
    #1;
    chk_main("rerun1", 1'b1, 8'd1, 16'h4201, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_main("arst_mid", 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);

    // PC wrap from RESET_PC = 8'hFE.
    @(posedge clk);
    #1;
    chk("wrap.reset_addr", {24'd0, w_addr}, 32'h0000_00FE);
    chk("wrap.reset_valid", {31'd0, w_valid}, 32'd0);
    w_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap.pc0", {24'd0, w_if_pc}, 32'h0000_00FE);
    chk("wrap.inst0", {16'd0, w_if_inst}, 32'h0000_01FE);
    chk("wrap.valid0", {31'd0, w_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("wrap.pc1", {24'd0, w_if_pc}, 32'h0000_00FF);
    chk("wrap.addr1", {24'd0, w_addr}, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("wrap.pc2", {24'd0, w_if_pc}, 32'h0000_0000);
    chk("wrap.inst2", {16'd0, w_if_inst}, 32'h0000_4103);
    chk("wrap.addr2", {24'd0, w_addr}, 32'h0000_0001);
    chk("wrap.halted", {31'd0, w_halted}, 32'd0);
    #3 w_rst_n = 1'b0;
    #1;
    chk("wrap.arst_valid", {31'd0, w_valid}, 32'd0);
    chk("wrap.arst_addr", {24'd0, w_addr}, 32'h0000_00FE);
    chk("wrap.arst_pc", {24'd0, w_if_pc}, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
